// File: rtl/flux_sched_pkg.sv
// flux_sched_pkg: shared FSM encodings and token/counter helpers for the flux burst scheduler
package flux_sched_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam int TOK_MAX = 64;
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int unsigned tok_tag(input logic [TOK_MAX-1:0] tok, input int dw, input int tw);
    return 32'((tok >> dw) & ((64'd1 << tw) - 64'd1));
  endfunction
  function automatic int unsigned tok_payload(input logic [TOK_MAX-1:0] tok, input int dw);
    return 32'(tok & ((64'd1 << dw) - 64'd1));
  endfunction
endpackage

// File: rtl/flux_token_fifo.sv
// flux_token_fifo: per-flux token buffer; the parent gates push so no overflow protection here
module flux_token_fifo
  import flux_sched_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int CW    = cnt_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  // pointers wrap naturally; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // storage needs no reset: emptiness is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/flux_rr_burst_scheduler.sv
// flux_rr_burst_scheduler: buffers tagged tokens per flux and emits RATE-token bursts round-robin
module flux_rr_burst_scheduler
  import flux_sched_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 8,
  parameter int RATE       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_port_write,
  input  logic [WIDTH-1:0] in_port_datain,
  output logic [FLUX-1:0]  in_port_full,
  output logic             out_port_write,
  output logic [WIDTH-1:0] out_port_dataout,
  input  logic             out_port_full,
  output logic             err_overflow
);
  localparam int CW = cnt_bits(DEPTH);
  localparam int FW = $clog2(FLUX);
  localparam int BW = $clog2(RATE) + 1;
  logic [0:0] state;
  logic [FW-1:0] rr, grant, sel, idx;
  logic found, popping, last_pop, drop;
  logic [BW-1:0] bcnt;
  logic [FLUX-1:0] push, pop;
  logic [CW-1:0] cnt [FLUX];
  logic [WIDTH-1:0] head [FLUX];
  logic [TAG_WIDTH-1:0] tag;
  assign tag      = TAG_WIDTH'(tok_tag(TOK_MAX'(in_port_datain), DATA_WIDTH, TAG_WIDTH));
  assign popping  = state == ST_BURST && !out_port_full;
  assign last_pop = popping && bcnt == BW'(RATE - 1);
  assign drop     = in_port_write && !(|push);
  genvar g;
  generate
    for (g = 0; g < FLUX; g++) begin : g_flux
      assign push[g] = in_port_write && tag == TAG_WIDTH'(g) && !in_port_full[g];
      assign pop[g]  = popping && grant == FW'(g);
      flux_token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push[g]),
        .din  (in_port_datain),
        .pop  (pop[g]),
        .dout (head[g]),
        .count(cnt[g]),
        .full (in_port_full[g])
      );
    end
  endgenerate
  // round-robin search from rr+1 for the first flux holding a full firing's worth of tokens
  always_comb begin
    found = 1'b0;
    sel   = rr;
    idx   = rr;
    for (int i = 1; i <= FLUX; i++) begin
      idx = FW'((int'(rr) + i) % FLUX);
      if (!found && cnt[idx] >= CW'(RATE)) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  // grant in IDLE, count pops in BURST, hand priority on after the last pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      rr    <= FW'(FLUX - 1);
      grant <= '0;
      bcnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        state <= ST_BURST;
        grant <= sel;
        bcnt  <= '0;
      end
    end else if (popping) begin
      bcnt <= bcnt + 1'b1;
      if (last_pop) begin
        state <= ST_IDLE;
        rr    <= grant;
      end
    end
  end
  // registered output: popped token appears the cycle after the pop, data holds while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_port_write   <= 1'b0;
      out_port_dataout <= '0;
    end else begin
      out_port_write <= popping;
      if (popping) out_port_dataout <= head[grant];
    end
  end
  // sticky flag for any dropped token (full buffer or out-of-range tag)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_overflow <= 1'b0;
    else if (drop) err_overflow <= 1'b1;
  end
endmodule

// File: tb/tb_flux_rr_burst_scheduler.sv
// tb_flux_rr_burst_scheduler: queue-based reference model with scoreboard monitor
module tb_flux_rr_burst_scheduler;
  localparam int FLUX = 2, DW = 8, DEPTH = 8, RATE = 4, W = 9;
  typedef struct {
    logic [W-1:0] tok;
    int           cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_port_write = 1'b0;
  logic [W-1:0] in_port_datain = '0;
  logic [FLUX-1:0] in_port_full;
  logic out_port_write;
  logic [W-1:0] out_port_dataout;
  logic out_port_full = 1'b0;
  logic err_overflow;
  int checks = 0, passes = 0, cyc = 0;
  logic [W-1:0] mq [FLUX][$];
  exp_t exp_q [$];
  exp_t mon_e;
  bit busy = 0, m_err = 0;
  int rr = FLUX - 1, gf = 0, rem = 0;

  flux_rr_burst_scheduler #(
    .FLUX(FLUX), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RATE(RATE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_port_write   (in_port_write),
    .in_port_datain  (in_port_datain),
    .in_port_full    (in_port_full),
    .out_port_write  (out_port_write),
    .out_port_dataout(out_port_dataout),
    .out_port_full   (out_port_full),
    .err_overflow    (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // one clock edge of the reference model: arbitration and pops see start-of-cycle occupancy
  task automatic model_step(input logic w, input logic [W-1:0] d, input logic of);
    int sz [FLUX];
    exp_t e;
    for (int f = 0; f < FLUX; f++) sz[f] = mq[f].size();
    if (!busy) begin
      for (int i = 1; i <= FLUX; i++) begin
        if (!busy && sz[(rr + i) % FLUX] >= RATE) begin
          busy = 1;
          gf   = (rr + i) % FLUX;
          rem  = RATE;
        end
      end
    end else if (!of) begin
      e.tok = mq[gf].pop_front();
      e.cyc = cyc;
      exp_q.push_back(e);
      rem--;
      if (rem == 0) begin
        busy = 0;
        rr   = gf;
      end
    end
    if (w) begin
      if (int'(d[W-1]) < FLUX && sz[d[W-1]] < DEPTH) mq[d[W-1]].push_back(d);
      else m_err = 1;
    end
  endtask

  task automatic cycle(input logic w, input logic [W-1:0] d, input logic of);
    in_port_write  = w;
    in_port_datain = d;
    out_port_full  = of;
    @(posedge clk);
    cyc++;
    if (rst) model_step(w, d, of);
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int f = 0; f < FLUX; f++) mq[f].delete();
    exp_q.delete();
    busy  = 0;
    rr    = FLUX - 1;
    m_err = 0;
    #1;
    check("rst_out_write", int'(out_port_write), 0);
    check("rst_out_data", int'(out_port_dataout), 0);
    check("rst_in_full", int'(in_port_full), 0);
    check("rst_err", int'(err_overflow), 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    rst = 1'b1;
  endtask

  // scoreboard monitor: every output token must match the model in value and cycle
  always @(negedge clk) begin
    if (out_port_write) begin
      if (exp_q.size() == 0) check("spurious_write", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("out_data", int'(out_port_dataout), int'(mon_e.tok));
        check("out_cycle", cyc, mon_e.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      check("missing_write", 0, 1);
    end
    check("in_port_full", int'(in_port_full), int'({mq[1].size() == DEPTH, mq[0].size() == DEPTH}));
    check("err_overflow", int'(err_overflow), int'(m_err));
  end

  initial begin
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, {1'b0, 8'(i)}, 1'b0);
    idle(8);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, {1'b0, 8'(i)}, 1'b0);
      cycle(1'b1, {1'b1, 8'(8'h10 + i)}, 1'b0);
    end
    cycle(1'b1, {1'b1, 8'h14}, 1'b0);
    idle(8);
    check("flux0_left_buffered", mq[0].size(), 3);
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 4; i++) begin
        cycle(1'b1, {1'b0, 8'(8'h40 + i)}, 1'b0);
        cycle(1'b1, {1'b1, 8'(8'h50 + i)}, 1'b0);
      end
      idle(14);
    end
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, {1'b0, 8'(8'h60 + i)}, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    idle(6);
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, {1'b1, 8'(8'h20 + i)}, 1'b1);
    cycle(1'b1, {1'b0, 8'h30}, 1'b1);
    cycle(1'b1, {1'b0, 8'h31}, 1'b1);
    idle(2);
    do_reset();
    idle(10);
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom_range(0, 99) < 60), W'($urandom), 1'($urandom_range(0, 99) < 25));
    idle(30);
    check("drain_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
